rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares a single 16-bit output channel among eight requesters. Each requester presents a 16-bit word with a request line. The arbiter picks one per cycle, steers its word through an 8-way 16-bit selector, and holds it in a one-entry output register drained by a valid/ready consumer. It sits in front of any shared 16-bit sink (memory write port, bus, ALU operand) that several producers must time-share.

## Interface
- Parameters: none (8 requesters, 16-bit words, fixed).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  8  `req[i]` = requester i has a word pending.
- `lock`  in  8  `lock[i]` = requester i asks to keep ownership after its current grant.
- `in_data`  in  128  word of requester i on bits `[16i+15:16i]`.
- `gnt`  out  8  one-hot; `gnt[i]` high for exactly the cycle in which requester i's word is captured.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  16  captured word.
- `out_src`  out  3  index of the requester that supplied `out_data`.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid && out_ready`.

## Operation
- **State**
  - `last` (3 bits): last granted index.
  - `owner` (3 bits) plus `locked` flag.
  - Output register: `out_valid`, `out_data`, `out_src`.
- **Reset values**
  - `last = 7`, so requester 0 wins first.
  - `locked = 0`, `owner = 0`.
  - `out_valid = 0`, `out_data = 0`, `out_src = 0`, `gnt = 0`.
- **Capture enable**: `cap_en = !out_valid || out_ready`, meaning the register is empty or draining this cycle.
- **Pick rule**, evaluated when `cap_en && |req`:
  - If `locked && req[owner]`, pick `owner`.
  - Otherwise pick the first `i` with `req[i]`, scanning `last+1, last+2, …` modulo 8 (wraps 7→0).
- **On pick of index p**:
  - `gnt[p]=1` combinationally in that cycle.
  - At the clock edge: `out_data <= in_data[p]`, `out_src <= p`, `out_valid <= 1`, `last <= p`.
  - Also at the edge: `owner <= p`, `locked <= lock[p]`.
- **No capture, draining**: if `cap_en` but no `req`, and `out_valid && out_ready`, then `out_valid <= 0`.
- **Stalled**: if `!cap_en` (`out_valid && !out_ready`), `gnt = 0` and all state holds. Requesters must keep `req` and data stable until they see their `gnt`.
- **Lock release**:
  - Lock ends when the owner is picked with `lock[owner]=0`.
  - Lock also ends when the owner drops `req` while a capture is possible (`cap_en && !req[owner]`): set `locked <= 0` and apply normal round-robin in the same cycle.
  - `lock[i]` from a non-owner is ignored.
- **States**
  - IDLE (`!out_valid`)
  - FULL_FREE (`out_valid && !locked`)
  - FULL_LOCKED (`out_valid && locked`)
  - Transitions follow the rules above; `reset` returns to IDLE from any state, discarding the held word.

## Timing
- Request to grant: 0 cycles when `cap_en` holds, since `gnt` is combinational from `req`, `lock` and state.
- Grant to `out_valid`: 1 cycle (registered).
- Throughput: one word per cycle while `out_ready=1` and `|req`; back-to-back captures need no bubble.
- Fairness: with all eight requesting and no locks, each requester is granted exactly once in any 8 consecutive captures.
- `out_data`, `out_src` and `out_valid` are stable while `out_valid && !out_ready`.
- Simultaneous drain and new request in one cycle: capture occurs and `out_valid` stays 1.
- Reset asserted mid-stall: next cycle `out_valid=0`, `gnt=0`, `last=7`.

## Structure
- Shared package (or `include` of constants):
  - `NREQ=8`, `WORD=16`, `IDXW=3`.
  - Slice macro for `in_data` lane i.
- Data steering reuses the existing 8-way 16-bit multiplexer, with select = picked index.
- One new sub-module, `rr_pick8`:
  - Combinational.
  - Inputs: `req[7:0]`, `last[2:0]`.
  - Outputs: `any`, `idx[2:0]`.
  - The rotate-then-priority-encode logic lives here.
- The top level holds only registers, lock logic and the `gnt` decode.

## Test plan
- Reset, then `req=8'b0000_0001`, `in_data` lane0 = 16'h1234, `out_ready=1` → `gnt=8'h01` that cycle; next cycle `out_valid=1`, `out_data=16'h1234`, `out_src=0`.
- `req=8'hFF` held, lane i = 16'h00A0+i, `out_ready=1` for 16 cycles → `out_src` sequence 0,1,…,7,0,…,7, no repeats within any 8.
- Word held in register, `out_ready=0` for 3 cycles with `req=8'h06` → `gnt=0`, `out_data` unchanged; on `out_ready=1`, `gnt=8'h02` in the same cycle.
- `req=8'h11`, `lock[0]=1` for 3 grants then 0 → `out_src` = 0,0,0,0,4; requester 4 is not granted until lock drops.
- `last=5`, `req=8'h21` → pick wraps to 0 (not 5); `out_src=0`, then 5 next.
- Assert `reset` while `out_valid=1`, `out_ready=0` → next cycle `out_valid=0`, `out_data=0`; first grant after release goes to the lowest requesting index.

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, types and lane selector for the eight-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int NREQ = 8;
    localparam int WORD = 16;
    localparam int IDXW = 3;

    typedef logic [IDXW-1:0] idx_t;
    typedef logic [WORD-1:0] word_t;

    // FULL_LOCKED implies a held word: the lock can only be set by a capture.
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_FULL_FREE   = 2'd1,
        ST_FULL_LOCKED = 2'd2
    } state_e;

    // 8-way 16-bit selector over the packed requester bus.
    function automatic word_t lane(input logic [NREQ*WORD-1:0] bus, input idx_t i);
        return bus[int'(i)*WORD +: WORD];
    endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping 7 -> 0.
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  idx_t            last,
    output logic            any,
    output idx_t            idx
);

    logic [NREQ-1:0] rot;
    idx_t            start;
    idx_t            off;

    assign start = last + idx_t'(1);

    // Rotate so bit 0 is the requester right after `last`, then priority-encode.
    always_comb begin
        rot = '0;
        off = '0;
        for (int j = 0; j < NREQ; j++) begin
            rot[j] = req[start + idx_t'(j)];
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = idx_t'(j);
            end
        end
        any = |rot;
        idx = start + off;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with lock: eight 16-bit requesters share one registered
// valid/ready output channel.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*WORD-1:0] in_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 out_valid,
    output logic [WORD-1:0]      out_data,
    output logic [IDXW-1:0]      out_src,
    input  logic                 out_ready
);

    state_e state_q, state_d;
    idx_t   last_q,  last_d;
    idx_t   owner_q, owner_d;
    word_t  data_q,  data_d;
    idx_t   src_q,   src_d;

    logic   rr_any;
    idx_t   rr_idx;
    idx_t   pick;
    logic   locked;
    logic   cap_en;
    logic   do_cap;

    rr_pick8 u_pick (
        .req  (req),
        .last (last_q),
        .any  (rr_any),
        .idx  (rr_idx)
    );

    assign locked = (state_q == ST_FULL_LOCKED);
    assign cap_en = (state_q == ST_IDLE) || out_ready;
    assign do_cap = cap_en && rr_any;
    // An owner that dropped its request falls back to plain round-robin here.
    assign pick   = (locked && req[owner_q]) ? owner_q : rr_idx;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        data_d  = data_q;
        src_d   = src_q;
        gnt     = '0;
        if (do_cap) begin
            gnt[pick] = 1'b1;
            state_d   = lock[pick] ? ST_FULL_LOCKED : ST_FULL_FREE;
            last_d    = pick;
            owner_d   = pick;
            data_d    = lane(in_data, pick);
            src_d     = pick;
        end else if (cap_en) begin
            // No requests: any held word drains, and a lock cannot survive.
            state_d = ST_IDLE;
        end
    end

    // ---- output / arbitration register stage ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= idx_t'(NREQ - 1);
            owner_q <= '0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = (state_q != ST_IDLE);
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: expected words are queued at grant time and
// compared while held and when accepted by the consumer.
module tb_rr_arbiter8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   req = '0;
    logic [7:0]   lock = '0;
    logic [127:0] in_data = '0;
    logic [7:0]   gnt;
    logic         out_valid;
    logic [15:0]  out_data;
    logic [2:0]   out_src;
    logic         out_ready = 1'b0;

    typedef struct packed {
        logic [2:0]  src;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t dummy;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    rr_arbiter8 dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .in_data   (in_data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req       = '0;
        lock      = '0;
        out_ready = 1'b0;
        in_data   = '0;
        cycle();
        cycle();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", out_data); end
        checks++;
        if (out_src !== 3'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", out_src); end
        checks++;
        if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h want 00", gnt); end
        cycle();
    endtask

    task automatic test_single();
        int         s;
        logic [7:0] eg;
        apply_reset();
        in_data[15:0] = 16'h1234;
        out_ready     = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req = (c == 0) ? 8'h01 : 8'h00;
            s   = (c == 0) ? 0 : -1;
            #1;
            eg = (s < 0) ? 8'h00 : 8'(1 << s);
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL single_gnt c=%0d: got %h want %h", c, gnt, eg); end
            checks++;
            if (out_valid !== (c == 1)) begin errors++; $display("FAIL single_valid c=%0d: got %b want %b", c, out_valid, (c == 1)); end
            if (out_valid && sb.size() != 0) begin
                checks++;
                if (out_src !== sb[0].src || out_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL single_word c=%0d: got src=%0d data=%h want src=%0d data=%h", c, out_src, out_data, sb[0].src, sb[0].data);
                end
                if (out_ready) dummy = sb.pop_front();
            end
            if (s >= 0) sb.push_back('{src: 3'(s), data: in_data[16*s +: 16]});
            cycle();
        end
    endtask

    task automatic test_fairness();
        int         s;
        logic [7:0] eg;
        logic       ev;
        apply_reset();
        for (int i = 0; i < 8; i++) in_data[16*i +: 16] = 16'h00A0 + 16'(i);
        out_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            req = (c < 16) ? 8'hFF : 8'h00;
            s   = (c < 16) ? (c % 8) : -1;
            ev  = (c >= 1 && c <= 16);
            #1;
            eg = (s < 0) ? 8'h00 : 8'(1 << s);
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL fair_gnt c=%0d: got %h want %h", c, gnt, eg); end
            checks++;
            if (out_valid !== ev) begin errors++; $display("FAIL fair_valid c=%0d: got %b want %b", c, out_valid, ev); end
            if (out_valid && sb.size() != 0) begin
                checks++;
                if (out_src !== sb[0].src || out_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL fair_word c=%0d: got src=%0d data=%h want src=%0d data=%h", c, out_src, out_data, sb[0].src, sb[0].data);
                end
                if (out_ready) dummy = sb.pop_front();
            end
            if (s >= 0) sb.push_back('{src: 3'(s), data: in_data[16*s +: 16]});
            cycle();
        end
    endtask

    task automatic test_stall();
        logic [7:0] r[8]  = '{8'h01, 8'h06, 8'h06, 8'h06, 8'h06, 8'h04, 8'h00, 8'h00};
        int         s[8]  = '{0, -1, -1, -1, 1, 2, -1, -1};
        logic [7:0] rd    = 8'b1111_0001;
        logic [7:0] v     = 8'b0111_1110;
        logic [7:0] eg;
        apply_reset();
        in_data[15:0]  = 16'h1111;
        in_data[31:16] = 16'h2222;
        in_data[47:32] = 16'h3333;
        for (int c = 0; c < 8; c++) begin
            req       = r[c];
            out_ready = rd[c];
            #1;
            eg = (s[c] < 0) ? 8'h00 : 8'(1 << s[c]);
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL stall_gnt c=%0d: got %h want %h", c, gnt, eg); end
            checks++;
            if (out_valid !== v[c]) begin errors++; $display("FAIL stall_valid c=%0d: got %b want %b", c, out_valid, v[c]); end
            if (out_valid && sb.size() != 0) begin
                checks++;
                if (out_src !== sb[0].src || out_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL stall_word c=%0d: got src=%0d data=%h want src=%0d data=%h", c, out_src, out_data, sb[0].src, sb[0].data);
                end
                if (out_ready) dummy = sb.pop_front();
            end
            if (s[c] >= 0) sb.push_back('{src: 3'(s[c]), data: in_data[16*s[c] +: 16]});
            cycle();
        end
    endtask

    task automatic test_lock();
        logic [7:0] r[7]  = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h00, 8'h00};
        logic [7:0] l[7]  = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        int         s[7]  = '{0, 0, 0, 0, 4, -1, -1};
        logic [7:0] v     = 8'b0011_1110;
        logic [7:0] eg;
        apply_reset();
        in_data[79:64] = 16'h4444;
        out_ready      = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req           = r[c];
            lock          = l[c];
            in_data[15:0] = 16'hAA00 + 16'(c);
            #1;
            eg = (s[c] < 0) ? 8'h00 : 8'(1 << s[c]);
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL lock_gnt c=%0d: got %h want %h", c, gnt, eg); end
            checks++;
            if (out_valid !== v[c]) begin errors++; $display("FAIL lock_valid c=%0d: got %b want %b", c, out_valid, v[c]); end
            if (out_valid && sb.size() != 0) begin
                checks++;
                if (out_src !== sb[0].src || out_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL lock_word c=%0d: got src=%0d data=%h want src=%0d data=%h", c, out_src, out_data, sb[0].src, sb[0].data);
                end
                if (out_ready) dummy = sb.pop_front();
            end
            if (s[c] >= 0) sb.push_back('{src: 3'(s[c]), data: in_data[16*s[c] +: 16]});
            cycle();
        end
        lock = '0;
    endtask

    task automatic test_wrap();
        logic [7:0] r[5]  = '{8'h20, 8'h21, 8'h21, 8'h00, 8'h00};
        int         s[5]  = '{5, 0, 5, -1, -1};
        logic [7:0] v     = 8'b0000_1110;
        logic [7:0] eg;
        apply_reset();
        in_data[95:80] = 16'h5555;
        in_data[15:0]  = 16'h0F0F;
        out_ready      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req = r[c];
            #1;
            eg = (s[c] < 0) ? 8'h00 : 8'(1 << s[c]);
            checks++;
            if (gnt !== eg) begin errors++; $display("FAIL wrap_gnt c=%0d: got %h want %h", c, gnt, eg); end
            checks++;
            if (out_valid !== v[c]) begin errors++; $display("FAIL wrap_valid c=%0d: got %b want %b", c, out_valid, v[c]); end
            if (out_valid && sb.size() != 0) begin
                checks++;
                if (out_src !== sb[0].src || out_data !== sb[0].data) begin
                    errors++;
                    $display("FAIL wrap_word c=%0d: got src=%0d data=%h want src=%0d data=%h", c, out_src, out_data, sb[0].src, sb[0].data);
                end
                if (out_ready) dummy = sb.pop_front();
            end
            if (s[c] >= 0) sb.push_back('{src: 3'(s[c]), data: in_data[16*s[c] +: 16]});
            cycle();
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        in_data[47:32]  = 16'h7777;
        in_data[63:48]  = 16'h3333;
        in_data[111:96] = 16'h6666;
        req       = 8'h04;
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 8'h04) begin errors++; $display("FAIL mid_first_gnt: got %h want 04", gnt); end
        cycle();
        req       = 8'h00;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h7777 || out_src !== 3'd2) begin
            errors++;
            $display("FAIL mid_held: got valid=%b data=%h src=%0d want 1 7777 2", out_valid, out_data, out_src);
        end
        cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (gnt !== 8'h00) begin errors++; $display("FAIL mid_stall_gnt: got %h want 00", gnt); end
        cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        checks++;
        if (out_data !== 16'h0000) begin errors++; $display("FAIL mid_rst_data: got %h want 0000", out_data); end
        checks++;
        if (out_src !== 3'd0) begin errors++; $display("FAIL mid_rst_src: got %0d want 0", out_src); end
        checks++;
        if (gnt !== 8'h00) begin errors++; $display("FAIL mid_rst_gnt: got %h want 00", gnt); end
        req       = 8'h48;
        out_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 8'h08) begin errors++; $display("FAIL mid_after_gnt: got %h want 08", gnt); end
        cycle();
        req = 8'h00;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h3333 || out_src !== 3'd3) begin
            errors++;
            $display("FAIL mid_after_word: got valid=%b data=%h src=%0d want 1 3333 3", out_valid, out_data, out_src);
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_lock();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
